// File: rtl/mag_arbiter.sv
// Round-robin arbiter that feeds atomic real/imag beat pairs from NCH receive channels
// into one shared magnitude-squared unit and tags each result with its source channel.
module mag_arbiter #(
    parameter int DW      = 16,
    parameter int NCH     = 4,
    parameter int TIMEOUT = 64,
    parameter int MAG_LAT = 2,
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] ch_data_i,
    input  logic [NCH-1:0]    ch_valid_i,
    input  logic [NCH-1:0]    ch_last_i,
    output logic [NCH-1:0]    ch_ready_o,
    output logic [DW-1:0]     data_o,
    output logic              valid_o,
    output logic              last_o,
    output logic [CW-1:0]     mag_chan_o,
    output logic              mag_chan_valid_o,
    output logic              err_o,
    output logic [15:0]       err_cnt_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REAL = 2'd1,
        S_IMAG = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   last_grant_q, last_grant_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [DW-1:0]   data_q;
    logic            valid_q, last_q, err_q;
    logic [15:0]     err_cnt_q;
    logic [MAG_LAT-1:0] dl_v_q;
    logic [CW-1:0]   dl_c_q [MAG_LAT];

    logic            sel_valid_s, sel_last_s, accept_s, fwd_s, err_s;
    logic [DW-1:0]   sel_data_s;

    // First requesting channel strictly after the previous winner, wrapping around.
    function automatic logic [CW-1:0] rr_pick(input logic [NCH-1:0] req, input logic [CW-1:0] prev);
        logic [CW-1:0] pick;
        logic          found;
        int            idx;
        pick  = prev;
        found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(prev) + k) % NCH;
            if (!found && req[idx]) begin
                pick  = CW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign sel_valid_s = ch_valid_i[grant_q];
    assign sel_last_s  = ch_last_i[grant_q];
    assign sel_data_s  = ch_data_i[int'(grant_q)*DW +: DW];
    assign accept_s    = (state_q != S_IDLE) && sel_valid_s;

    // State register plus datapath, error counter and result-tag delay line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= CW'(NCH - 1);
            tmo_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= 16'h0000;
            dl_v_q       <= '0;
            for (int i = 0; i < MAG_LAT; i++) begin
                dl_c_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tmo_q        <= tmo_d;
            data_q       <= fwd_s ? sel_data_s : '0;
            valid_q      <= fwd_s;
            last_q       <= fwd_s && (state_q == S_IMAG);
            err_q        <= err_s;
            err_cnt_q    <= (err_s && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
            // last_grant_q already names the pair whose imag beat is on last_o.
            dl_v_q[0]    <= last_q;
            dl_c_q[0]    <= last_grant_q;
            for (int i = 1; i < MAG_LAT; i++) begin
                dl_v_q[i] <= dl_v_q[i-1];
                dl_c_q[i] <= dl_c_q[i-1];
            end
        end
    end

    // Next-state logic: grant selection, beat acceptance, protocol errors and timeout.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tmo_d        = tmo_q;
        fwd_s        = 1'b0;
        err_s        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|ch_valid_i) begin
                    grant_d = rr_pick(ch_valid_i, last_grant_q);
                    state_d = S_REAL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REAL: begin
                if (accept_s && !sel_last_s) begin
                    fwd_s   = 1'b1;
                    tmo_d   = '0;
                    state_d = S_IMAG;
                end else if (accept_s) begin
                    err_s   = 1'b1;
                end else begin
                    state_d = S_REAL;
                end
            end
            S_IMAG: begin
                if (accept_s && sel_last_s) begin
                    fwd_s        = 1'b1;
                    last_grant_d = grant_q;
                    tmo_d        = '0;
                    state_d      = S_IDLE;
                end else begin
                    // A stray real beat and an expiring timeout in one cycle give one pulse.
                    err_s = accept_s;
                    if (tmo_q == TW'(TIMEOUT - 1)) begin
                        err_s        = 1'b1;
                        last_grant_d = grant_q;
                        tmo_d        = '0;
                        state_d      = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    // Output decode: only the granted channel sees ready while a pair is open.
    always_comb begin
        ch_ready_o = '0;
        if ((state_q == S_REAL) || (state_q == S_IMAG)) begin
            ch_ready_o[grant_q] = 1'b1;
        end else begin
            ch_ready_o = '0;
        end
    end

    assign data_o           = data_q;
    assign valid_o          = valid_q;
    assign last_o           = last_q;
    assign err_o            = err_q;
    assign err_cnt_o        = err_cnt_q;
    assign mag_chan_o       = dl_c_q[MAG_LAT-1];
    assign mag_chan_valid_o = dl_v_q[MAG_LAT-1];

endmodule

// File: tb/tb_mag_arbiter.sv
// Self-checking bench for mag_arbiter: directed vector table, corner sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_mag_arbiter;

    localparam int DW = 16, NCH = 4, TIMEOUT = 64, MAG_LAT = 2, CW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NCH*DW-1:0] ch_data = '0;
    logic [NCH-1:0]    ch_valid = '0, ch_last = '0;
    logic [NCH-1:0]    ch_ready_o;
    logic [DW-1:0]     data_o;
    logic              valid_o, last_o, mag_chan_valid_o, err_o;
    logic [CW-1:0]     mag_chan_o;
    logic [15:0]       err_cnt_o;

    mag_arbiter #(.DW(DW), .NCH(NCH), .TIMEOUT(TIMEOUT), .MAG_LAT(MAG_LAT)) dut (
        .clk(clk), .rst(rst), .ch_data_i(ch_data), .ch_valid_i(ch_valid), .ch_last_i(ch_last),
        .ch_ready_o(ch_ready_o), .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
        .mag_chan_o(mag_chan_o), .mag_chan_valid_o(mag_chan_valid_o),
        .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (pair/transaction level) ----------------
    typedef struct { int at; int ch; } mag_t;
    mag_t magq[$];
    int   m_cyc = 0, m_phase = 0, m_grant = 0, m_lg = NCH - 1, m_wait = 0, m_cnt = 0;
    logic e_valid, e_last, e_err;
    logic [DW-1:0] e_data;

    function automatic void model_step(input logic r, input logic [NCH-1:0] v, input logic [NCH-1:0] l,
                                       input logic [NCH*DW-1:0] d);
        m_cyc++;
        e_valid = 1'b0; e_last = 1'b0; e_err = 1'b0; e_data = '0;
        if (!r) begin
            m_phase = 0; m_lg = NCH - 1; m_wait = 0; m_cnt = 0;
            magq.delete();
            return;
        end
        if (m_phase == 0) begin
            if (v != '0) begin
                for (int k = 1; k <= NCH; k++) begin
                    if (v[(m_lg + k) % NCH]) begin
                        m_grant = (m_lg + k) % NCH;
                        break;
                    end
                end
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (v[m_grant] && !l[m_grant]) begin
                e_valid = 1'b1; e_data = d[m_grant*DW +: DW];
                m_phase = 2; m_wait = 0;
            end else if (v[m_grant]) e_err = 1'b1;
        end else begin
            if (v[m_grant] && l[m_grant]) begin
                e_valid = 1'b1; e_last = 1'b1; e_data = d[m_grant*DW +: DW];
                m_lg = m_grant; m_phase = 0;
                magq.push_back('{at: m_cyc + MAG_LAT, ch: m_grant});
            end else begin
                if (v[m_grant]) e_err = 1'b1;
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    e_err = 1'b1; m_lg = m_grant; m_phase = 0;
                end
            end
        end
        if (e_err && m_cnt < 65535) m_cnt++;
    endfunction

    task automatic model_compare(input logic r);
        logic e_mv;
        int   e_mc;
        logic [NCH-1:0] e_rdy;
        e_rdy = '0;
        if (m_phase != 0) e_rdy[m_grant] = 1'b1;
        e_mv = 1'b0; e_mc = 0;
        if (magq.size() > 0 && magq[0].at == m_cyc) begin
            e_mv = 1'b1; e_mc = magq[0].ch;
            void'(magq.pop_front());
        end
        chk("ready", ch_ready_o, e_rdy);
        chk("valid_o", valid_o, e_valid);
        chk("last_o", last_o, e_last);
        chk("err_o", err_o, e_err);
        chk("err_cnt_o", err_cnt_o, m_cnt);
        chk("mag_valid", mag_chan_valid_o, e_mv);
        if (e_valid || !r) chk("data_o", data_o, e_data);
        if (e_mv || !r) chk("mag_chan", mag_chan_o, e_mc);
    endtask

    // One clock: drive on the falling edge, check 1 time unit after the rising edge.
    task automatic step(input logic r, input logic [NCH-1:0] v, input logic [NCH-1:0] l,
                        input logic [NCH*DW-1:0] d);
        rst = r; ch_valid = v; ch_last = l; ch_data = d;
        @(posedge clk);
        #1;
        model_step(r, v, l, d);
        model_compare(r);
        @(negedge clk);
    endtask

    function automatic logic [NCH*DW-1:0] put(input int ch, input logic [DW-1:0] val);
        logic [NCH*DW-1:0] r;
        r = '0;
        r[ch*DW +: DW] = val;
        return r;
    endfunction

    // Well-behaved sources: alternate real/imag per channel, occasionally send the wrong marker.
    logic [NCH-1:0] src_last = '0;
    task automatic src_step(input logic [NCH-1:0] vm, input int bad_pct, input logic coded);
        logic [NCH-1:0] rdy_b, l;
        logic [NCH*DW-1:0] d;
        rdy_b = ch_ready_o;
        for (int c = 0; c < NCH; c++) begin
            l[c] = src_last[c];
            if (int'($urandom_range(99)) < bad_pct) l[c] = ~l[c];
            d[c*DW +: DW] = coded ? DW'((c << 8) | int'(l[c])) : DW'($urandom);
        end
        step(1'b1, vm, l, d);
        for (int c = 0; c < NCH; c++)
            if (rdy_b[c] && vm[c]) src_last[c] = ~l[c];
    endtask

    task automatic do_reset();
        step(1'b0, '0, '0, '0);
        src_last = '0;
    endtask

    typedef struct {
        logic r; logic [NCH-1:0] v, l; logic [NCH*DW-1:0] d;
        logic [NCH-1:0] rdy; logic ov, ol; logic [DW-1:0] od; logic mv; logic [CW-1:0] mc;
        logic eo; logic [15:0] ec;
    } vec_t;

    vec_t tv[13];

    initial begin
        // Directed vectors: expected outputs after the edge that consumes each row's inputs.
        tv[0]  = '{1'b0, 4'b0000, 4'b0000, put(0, 16'h0000), 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 16'd0};
        tv[1]  = '{1'b1, 4'b0010, 4'b0000, put(1, 16'h0003), 4'b0010, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 16'd0};
        tv[2]  = '{1'b1, 4'b0010, 4'b0000, put(1, 16'h0003), 4'b0010, 1'b1, 1'b0, 16'h0003, 1'b0, 2'd0, 1'b0, 16'd0};
        tv[3]  = '{1'b1, 4'b0010, 4'b0010, put(1, 16'h0004), 4'b0000, 1'b1, 1'b1, 16'h0004, 1'b0, 2'd0, 1'b0, 16'd0};
        tv[4]  = '{1'b1, 4'b0000, 4'b0000, put(0, 16'h0000), 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 16'd0};
        tv[5]  = '{1'b1, 4'b0000, 4'b0000, put(0, 16'h0000), 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 1'b0, 16'd0};
        tv[6]  = '{1'b1, 4'b0000, 4'b0000, put(0, 16'h0000), 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 16'd0};
        tv[7]  = '{1'b1, 4'b0100, 4'b0100, put(2, 16'h0009), 4'b0100, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 16'd0};
        tv[8]  = '{1'b1, 4'b0100, 4'b0100, put(2, 16'h0009), 4'b0100, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 16'd1};
        tv[9]  = '{1'b1, 4'b0100, 4'b0000, put(2, 16'h0007), 4'b0100, 1'b1, 1'b0, 16'h0007, 1'b0, 2'd0, 1'b0, 16'd1};
        tv[10] = '{1'b1, 4'b0100, 4'b0100, put(2, 16'h0008), 4'b0000, 1'b1, 1'b1, 16'h0008, 1'b0, 2'd0, 1'b0, 16'd1};
        tv[11] = '{1'b1, 4'b0000, 4'b0000, put(0, 16'h0000), 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 16'd1};
        tv[12] = '{1'b1, 4'b0000, 4'b0000, put(0, 16'h0000), 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd2, 1'b0, 16'd1};

        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            step(tv[i].r, tv[i].v, tv[i].l, tv[i].d);
            chk("tbl_ready", ch_ready_o, tv[i].rdy);
            chk("tbl_valid", valid_o, tv[i].ov);
            chk("tbl_last", last_o, tv[i].ol);
            if (tv[i].ov || !tv[i].r) chk("tbl_data", data_o, tv[i].od);
            chk("tbl_magv", mag_chan_valid_o, tv[i].mv);
            if (tv[i].mv || !tv[i].r) chk("tbl_magc", mag_chan_o, tv[i].mc);
            chk("tbl_err", err_o, tv[i].eo);
            chk("tbl_errcnt", err_cnt_o, tv[i].ec);
        end

        // All channels continuously valid: pairs in order 0,1,2,3,0, one every 3 cycles.
        begin
            logic [DW-1:0] beats[$];
            int imag_at[$];
            do_reset();
            for (int s = 1; s <= 16; s++) begin
                src_step(4'b1111, 0, 1'b1);
                if (valid_o) begin
                    beats.push_back(data_o);
                    if (last_o) imag_at.push_back(s);
                end
            end
            chk("rr_beats", beats.size(), 10);
            for (int p = 0; p < 5 && 2*p+1 < beats.size(); p++) begin
                chk("rr_real", beats[2*p], DW'((p % NCH) << 8));
                chk("rr_imag", beats[2*p+1], DW'(((p % NCH) << 8) | 1));
            end
            for (int p = 1; p < imag_at.size(); p++)
                chk("rr_spacing", imag_at[p] - imag_at[p-1], 3);
        end

        // Timeout: ch0 real accepted then ch0 silent; ch1 waits and gets the next grant.
        begin
            int first_err = -1;
            logic any_mag = 1'b0;
            do_reset();
            src_step(4'b0001, 0, 1'b1);
            src_step(4'b0011, 0, 1'b1);
            chk("to_real_fwd", valid_o, 1'b1);
            for (int k = 1; k <= 65; k++) begin
                src_step(4'b0010, 0, 1'b1);
                if (err_o && first_err < 0) first_err = k;
                any_mag |= mag_chan_valid_o;
            end
            chk("to_err_cycle", first_err, TIMEOUT);
            chk("to_next_grant", ch_ready_o, 4'b0010);
            chk("to_no_mag", any_mag, 1'b0);
            chk("to_errcnt", err_cnt_o, 16'd1);
        end

        // Reset while in IMAG: outputs clear, no error, next grant restarts at ch0.
        begin
            logic any_mag = 1'b0;
            do_reset();
            step(1'b1, 4'b0100, 4'b0000, put(2, 16'h1234));
            step(1'b1, 4'b0100, 4'b0000, put(2, 16'h1234));
            chk("rs_in_imag", ch_ready_o, 4'b0100);
            step(1'b0, 4'b0100, 4'b0100, put(2, 16'h5678));
            chk("rs_ready", ch_ready_o, 4'b0000);
            chk("rs_valid", valid_o, 1'b0);
            chk("rs_err", err_o, 1'b0);
            src_last = '0;
            step(1'b1, 4'b1111, 4'b0000, '0);
            chk("rs_next_grant", ch_ready_o, 4'b0001);
            for (int k = 0; k < 4; k++) begin
                step(1'b1, 4'b0000, 4'b0000, '0);
                any_mag |= mag_chan_valid_o;
            end
            chk("rs_no_mag", any_mag, 1'b0);
        end

        // Error counter saturation: ch0 keeps sending imag beats while in REAL.
        do_reset();
        step(1'b1, 4'b0001, 4'b0001, '0);
        for (int k = 0; k < 65540; k++) step(1'b1, 4'b0001, 4'b0001, '0);
        chk("sat_cnt", err_cnt_o, 16'hFFFF);
        chk("sat_err", err_o, 1'b1);

        // Randomized traffic with bad markers, starvation windows and occasional resets.
        do_reset();
        for (int s = 0; s < 2000; s++) begin
            if ($urandom_range(299) == 0) do_reset();
            else src_step((s % 500 >= 420) ? 4'b0000 : NCH'($urandom), 6, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mag_arbiter.md
MAG_ARBITER -- requirements
Module: mag_arbiter

Interface
REQ-001 Parameter: DW, 16, sample width of one real or imag beat.
REQ-002 Parameter: NCH, 4, number of requesting receive channels (2..8).
REQ-003 Parameter: TIMEOUT, 64, max cycles from real-beat accept to imag-beat accept.
REQ-004 Parameter: MAG_LAT, 2, cycles from last_o beat to matching result at the shared magnitude-squared unit output.
REQ-005 Ports: clk  in  1  sole clock; all logic on rising edge.
REQ-006 Ports: rst  in  1  reset; synchronous, active-low.
REQ-007 Ports: ch_data_i  in  NCH*DW  per-channel interleaved real/imag beats; channel i at bits [i*DW +: DW].
REQ-008 Ports: ch_valid_i  in  NCH  per-channel beat valid.
REQ-009 Ports: ch_last_i  in  NCH  per-channel beat marker; 0 = real, 1 = imag.
REQ-010 Ports: ch_ready_o  out  NCH  per-channel accept; at most one bit high.
REQ-011 Ports: data_o  out  DW  beat to the shared magnitude-squared unit.
REQ-012 Ports: valid_o  out  1  beat valid to the shared unit; no backpressure.
REQ-013 Ports: last_o  out  1  imag-beat marker to the shared unit.
REQ-014 Ports: mag_chan_o  out  clog2(NCH)  channel index of the result emerging from the shared unit.
REQ-015 Ports: mag_chan_valid_o  out  1  high for exactly the cycle the shared unit's result for that channel is valid.
REQ-016 Ports: err_o  out  1  one-cycle pulse on protocol error or timeout.
REQ-017 Ports: err_cnt_o  out  16  saturating error count.

Function
REQ-018 Beat transfer on channel i SHALL occur when ch_valid_i[i] && ch_ready_o[i].
REQ-019 FSM states SHALL be IDLE, REAL, IMAG.
REQ-020 IDLE: no ready asserted; if any ch_valid_i set, grant the first valid channel in round-robin order starting at (last_grant+1) mod NCH and go to REAL the next cycle; otherwise stay in IDLE.
REQ-021 REAL: ch_ready_o[grant]=1; real beat (last=0) accepted -> forward it and go to IMAG.
REQ-022 REAL: imag beat (last=1) accepted -> discard it, pulse err_o, stay in REAL.
REQ-023 IMAG: ch_ready_o[grant]=1; imag beat accepted -> forward it with last_o=1, update last_grant, go to IDLE.
REQ-024 IMAG: real beat accepted -> discard it, pulse err_o, stay in IMAG.
REQ-025 IMAG: timeout counter clears on real-beat accept and increments each IMAG cycle; on reaching TIMEOUT with no imag accept -> pulse err_o, update last_grant, go to IDLE, forward nothing.
REQ-026 A real beat SHALL always be followed on data_o by its own channel's imag beat before any other beat (pairs atomic, never interleaved).
REQ-027 data_o/valid_o/last_o SHALL be registered: an accepted beat appears exactly 1 cycle after transfer; valid_o=0 otherwise.
REQ-028 A pair aborted by timeout SHALL leave an orphan real beat at the shared unit; no mag_chan_valid_o SHALL be produced for it.
REQ-029 On each last_o=1 output cycle, the grant index SHALL enter a MAG_LAT-deep delay line; mag_chan_o/mag_chan_valid_o SHALL emerge MAG_LAT cycles later.
REQ-030 Round-robin is fair: with all channels continuously valid, grants rotate 0,1,..,NCH-1,0; each pair takes 3 cycles minimum (IDLE, REAL, IMAG).
REQ-031 err_cnt_o SHALL increment once per err_o pulse and saturate at 16'hFFFF.
REQ-032 err_o SHALL pulse at most once per cycle; simultaneous error sources count as one.

Reset
REQ-033 While rst=0 at a clock edge: state=IDLE, last_grant=NCH-1, ch_ready_o=0, data_o=0, valid_o=0, last_o=0, delay line cleared, mag_chan_o=0, mag_chan_valid_o=0, err_o=0, err_cnt_o=0, timeout counter=0.
REQ-034 Reset mid-pair SHALL abandon the pair silently, with no err_o pulse and no mag_chan_valid_o for it.

Verification
REQ-035 Only ch1 valid, beats 0x0003 (last=0), 0x0004 (last=1) -> data_o 0x0003 then 0x0004 with last_o=1; mag_chan_o=1 with mag_chan_valid_o MAG_LAT cycles after last_o.
REQ-036 All 4 channels continuously valid from reset -> grant order 0,1,2,3,0; one pair every 3 cycles; no interleaving on data_o.
REQ-037 Granted ch2 sends last=1 first -> beat dropped, err_o pulse, err_cnt_o=1, channel stays in REAL; the following valid pair is forwarded normally.
REQ-038 ch0 real accepted, ch0_valid then held 0 for TIMEOUT=64 cycles -> err_o pulse, FSM to IDLE, next grant ch1, no mag_chan_valid_o for ch0.
REQ-039 rst=0 asserted in IMAG state -> all outputs at reset values on the next cycle; the next grant after release goes to ch0.
REQ-040 Force 65536 errors -> err_cnt_o holds 16'hFFFF.
